cnn_rd_fetch: RTL and testbench
===============================

# cnn_rd_fetch

Row fetcher that sits directly upstream of the `cnn` compute block on one memory read port, either picture or weight; one instance is used per port. Given a base address, row stride, row count and bytes per row from the software registers, it issues one read request per row on the memory read interface. It assembles the returned 128-bit beats into a single row buffer and hands each complete row to `cnn` over a valid/ready handshake. It is single-buffered: the next row is requested only after the current row has been consumed.

## Interface
- ADDR_WIDTH, 12: memory byte-address width.
- MEM_DATA_BUS, 128: memory read data width (16 bytes per beat).
- MAX_BYTES_TO_RD, 20: maximum bytes per row.
- LOG2_MAX_BYTES_TO_RD, $clog2(MAX_BYTES_TO_RD)=5: width of the byte-count fields.

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that launches a job; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  address of the first byte of row 0.
- row_stride  in  ADDR_WIDTH  address increment between rows.
- rows  in  8  number of rows to fetch.
- row_bytes  in  LOG2_MAX_BYTES_TO_RD  bytes per row.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at job completion.
- mem_start_addr  out  ADDR_WIDTH  row read address.
- mem_bytes  out  LOG2_MAX_BYTES_TO_RD  bytes requested.
- mem_rd_req  out  1  read request, held until the first data beat arrives.
- mem_data  in  MEM_DATA_BUS  read data beat, little-endian (byte 0 in bits [7:0]).
- mem_data_vld  in  1  beat valid.
- row_data  out  MAX_BYTES_TO_RD*8  assembled row; byte k is in bits [8k+7:8k].
- row_vld  out  1  row_data valid.
- row_rdy  in  1  `cnn` accepts the row.

## Operation
- FSM states are IDLE, REQ, RECV, OUT and FIN.
- IDLE to REQ: on start, latch base_addr, row_stride, rows and row_bytes; clamp row_bytes to MAX_BYTES_TO_RD; set addr=base_addr and row_cnt=0.
  - If rows==0 or row_bytes==0, go IDLE to FIN instead; no memory request is issued.
- REQ: drive mem_rd_req=1, mem_start_addr=addr and mem_bytes=latched row_bytes. These stay stable until mem_data_vld.
  - The first beat is captured in REQ; the FSM then moves to RECV, or directly to OUT if the row needs only one beat.
- Beats per row is ceil(row_bytes/16), so 1 or 2 with the defaults.
  - Beat b fills buffer bytes 16b .. 16b+15.
  - Buffer bytes at index ≥ row_bytes are forced to 0.
  - Gaps (cycles with mem_data_vld=0) between beats are allowed.
- RECV: wait for the remaining beats, capture each one, then go to OUT after the last beat.
- OUT: row_vld=1 and row_data is stable. On row_vld&&row_rdy:
  - increment row_cnt;
  - set addr = addr + row_stride, modulo 2^ADDR_WIDTH (wrap, no error);
  - go to REQ, or to FIN if row_cnt+1 == rows.
- FIN: done=1 for one cycle, busy drops, return to IDLE.
- start pulses outside IDLE are ignored.
- mem_data_vld is ignored in IDLE, OUT and FIN. A beat arriving in those states is dropped and does not corrupt the buffer.
- rst asserted at any time, including mid-row:
  - state goes to IDLE and counters clear;
  - all outputs go to 0, including row_data;
  - an outstanding memory request is abandoned.

## Timing
- Reset values: busy=0, done=0, mem_rd_req=0, mem_start_addr=0, mem_bytes=0, row_vld=0, row_data=0.
- start in cycle T: mem_rd_req=1 in T+1 and busy=1 in T+1.
- If start arrives with rows==0 or row_bytes==0: done=1 in T+1, busy stays 0.
- First beat valid in cycle V: mem_rd_req=0 in V+1.
- Last beat in cycle L: row_vld=1 in L+1.
- Handshake in cycle H:
  - if rows remain, row_vld=0 and mem_rd_req=1 with the new address in H+1;
  - on the last row, done=1 and busy=0 in H+1.
- All outputs are registered. There is no combinational path from mem_data_vld or row_rdy to any output.
- row_vld held without row_rdy keeps row_data unchanged indefinitely.

## Test plan
- **Single row, one beat.** Stimulus: base=0x100, rows=1, row_bytes=9; memory returns bytes 0x00..0x0F one cycle after the request.
  - Required: one request with addr=0x100 and bytes=9.
  - row_data bytes 0..8 = 0x00..0x08, bytes 9..19 = 0.
  - done is asserted one cycle after the row handshake.
- **Two-beat rows with gaps.** Stimulus: rows=3, row_bytes=20, stride=0x20; a 2-cycle vld gap between beats.
  - Required: request addresses 0x100, 0x120, 0x140.
  - Each row_data holds beat0 bytes 0..15 and beat1 bytes 0..3 in bytes 16..19.
- **Backpressure.** Stimulus: row_rdy held low for 10 cycles.
  - Required: row_vld and row_data stay stable, with no new request until the handshake.
  - A stray mem_data_vld during OUT is ignored.
- **Address wrap.** Stimulus: base=0xFF0, stride=0x20, rows=2.
  - Required: second request addr=0x010.
- **Degenerate jobs.** Stimulus: rows=0, then row_bytes=0, then row_bytes=31.
  - Required: done in T+1 with no mem_rd_req for the first two cases.
  - row_bytes=31 is clamped to 20, giving mem_bytes=20.
- **Reset and start while busy.** Stimulus: rst asserted mid-RECV, then a new job; separately, a start pulse while busy.
  - Required: after rst, outputs are 0 immediately and the next job runs cleanly.
  - The start pulse while busy has no effect.

Source files
------------

// File: rtl/cnn_rd_fetch.sv
// Row fetcher feeding the cnn compute block from one memory read port.
// Requests one row at a time, assembles 128-bit beats into a row buffer, and hands the row over valid/ready.
module cnn_rd_fetch #(
   parameter int ADDR_WIDTH           = 12,
   parameter int MEM_DATA_BUS         = 128,
   parameter int MAX_BYTES_TO_RD      = 20,
   parameter int LOG2_MAX_BYTES_TO_RD = $clog2(MAX_BYTES_TO_RD)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [ADDR_WIDTH-1:0]           base_addr,
   input  logic [ADDR_WIDTH-1:0]           row_stride,
   input  logic [7:0]                      rows,
   input  logic [LOG2_MAX_BYTES_TO_RD-1:0] row_bytes,
   output logic                            busy,
   output logic                            done,
   output logic [ADDR_WIDTH-1:0]           mem_start_addr,
   output logic [LOG2_MAX_BYTES_TO_RD-1:0] mem_bytes,
   output logic                            mem_rd_req,
   input  logic [MEM_DATA_BUS-1:0]         mem_data,
   input  logic                            mem_data_vld,
   output logic [MAX_BYTES_TO_RD*8-1:0]    row_data,
   output logic                            row_vld,
   input  logic                            row_rdy
);

   localparam int BYTES_PER_BEAT = MEM_DATA_BUS / 8;
   localparam int BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);
   localparam int CNT_W          = LOG2_MAX_BYTES_TO_RD + 1;
   localparam logic [CNT_W-1:0] BEAT_ROUND = CNT_W'(BYTES_PER_BEAT - 1);
   localparam logic [LOG2_MAX_BYTES_TO_RD-1:0] MAX_BYTES = LOG2_MAX_BYTES_TO_RD'(MAX_BYTES_TO_RD);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      RECV,
      OUT,
      FIN
   } state_t;

   state_t state;
   state_t state_next;

   logic [ADDR_WIDTH-1:0]           addr;
   logic [ADDR_WIDTH-1:0]           stride;
   logic [7:0]                      rows_q;
   logic [7:0]                      row_cnt;
   logic [LOG2_MAX_BYTES_TO_RD-1:0] bytes_q;
   logic [LOG2_MAX_BYTES_TO_RD-1:0] bytes_clamped;
   logic [CNT_W-1:0]                beat_idx;
   logic [CNT_W-1:0]                beats_needed;
   logic [MAX_BYTES_TO_RD*8-1:0]    row_buf;
   logic [MAX_BYTES_TO_RD*8-1:0]    buf_next;
   logic                            capture;
   logic                            last_beat;
   logic                            last_row;
   logic                            degenerate;

   assign mem_start_addr = addr;
   assign mem_bytes      = bytes_q;
   assign row_data       = row_buf;

   always_comb begin
      bytes_clamped = (row_bytes > MAX_BYTES) ? MAX_BYTES : row_bytes;
      beats_needed  = ({1'b0, bytes_q} + BEAT_ROUND) >> BEAT_SHIFT;
      last_beat     = (beat_idx == beats_needed - CNT_W'(1));
      capture       = mem_data_vld && ((state == REQ) || (state == RECV));
      last_row      = ((row_cnt + 8'd1) == rows_q);
      degenerate    = (rows == 8'd0) || (row_bytes == '0);
   end

   // The first beat of a row also clears the bytes of later beats so a short
   // row never shows leftovers from a longer previous row.
   always_comb begin
      buf_next = row_buf;
      if (capture) begin
         for (int k = 0; k < MAX_BYTES_TO_RD; k++) begin
            if (CNT_W'(k / BYTES_PER_BEAT) == beat_idx) begin
               if (LOG2_MAX_BYTES_TO_RD'(k) < bytes_q) begin
                  buf_next[8*k +: 8] = mem_data[8*(k % BYTES_PER_BEAT) +: 8];
               end else begin
                  buf_next[8*k +: 8] = 8'h00;
               end
            end else if ((beat_idx == '0) && (k >= BYTES_PER_BEAT)) begin
               buf_next[8*k +: 8] = 8'h00;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Outputs decode only the state register, so nothing reaches them
   // combinationally from mem_data_vld or row_rdy.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      mem_rd_req = 1'b0;
      row_vld    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = degenerate ? FIN : REQ;
            end
         end
         REQ: begin
            busy       = 1'b1;
            mem_rd_req = 1'b1;
            if (capture) begin
               state_next = last_beat ? OUT : RECV;
            end
         end
         RECV: begin
            busy = 1'b1;
            if (capture && last_beat) begin
               state_next = OUT;
            end
         end
         OUT: begin
            busy    = 1'b1;
            row_vld = 1'b1;
            if (row_rdy) begin
               state_next = last_row ? FIN : REQ;
            end
         end
         FIN: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr     <= '0;
         stride   <= '0;
         rows_q   <= '0;
         row_cnt  <= '0;
         bytes_q  <= '0;
         beat_idx <= '0;
         row_buf  <= '0;
      end else begin
         row_buf <= buf_next;
         case (state)
            IDLE: begin
               if (start) begin
                  addr     <= base_addr;
                  stride   <= row_stride;
                  rows_q   <= rows;
                  bytes_q  <= bytes_clamped;
                  row_cnt  <= '0;
                  beat_idx <= '0;
               end
            end
            REQ, RECV: begin
               if (capture) begin
                  beat_idx <= last_beat ? '0 : beat_idx + CNT_W'(1);
               end
            end
            OUT: begin
               if (row_rdy) begin
                  row_cnt <= row_cnt + 8'd1;
                  addr    <= addr + stride;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cnn_rd_fetch.sv
// Directed bench for cnn_rd_fetch: a bench-side memory answers each row request,
// expected rows go through a scoreboard queue and are compared when row_vld rises.
module tb_cnn_rd_fetch;

   localparam int AW = 12;
   localparam int DW = 128;
   localparam int MB = 20;
   localparam int LB = 5;
   localparam int RW = MB * 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW-1:0] row_stride;
   logic [7:0]    rows;
   logic [LB-1:0] row_bytes;
   logic          busy;
   logic          done;
   logic [AW-1:0] mem_start_addr;
   logic [LB-1:0] mem_bytes;
   logic          mem_rd_req;
   logic [DW-1:0] mem_data;
   logic          mem_data_vld;
   logic [RW-1:0] row_data;
   logic          row_vld;
   logic          row_rdy;

   int n_checks = 0;
   int n_errors = 0;

   logic [RW-1:0] sb_q[$];

   cnn_rd_fetch #(
      .ADDR_WIDTH(AW),
      .MEM_DATA_BUS(DW),
      .MAX_BYTES_TO_RD(MB),
      .LOG2_MAX_BYTES_TO_RD(LB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .base_addr(base_addr),
      .row_stride(row_stride),
      .rows(rows),
      .row_bytes(row_bytes),
      .busy(busy),
      .done(done),
      .mem_start_addr(mem_start_addr),
      .mem_bytes(mem_bytes),
      .mem_rd_req(mem_rd_req),
      .mem_data(mem_data),
      .mem_data_vld(mem_data_vld),
      .row_data(row_data),
      .row_vld(row_vld),
      .row_rdy(row_rdy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [RW-1:0] observed, input logic [RW-1:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [AW-1:0] b, input logic [AW-1:0] s,
                                input logic [7:0] n, input logic [LB-1:0] nb);
      base_addr  = b;
      row_stride = s;
      rows       = n;
      row_bytes  = nb;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   // Serves one row request: checks the request, returns beats, checks the row, then hands it off.
   task automatic serveRow(input logic [AW-1:0] exp_addr, input logic [LB-1:0] eb, input logic [7:0] dbase,
                           input int gap, input int bp, input bit stray);
      int            waited;
      int            nb;
      logic [RW-1:0] exp_row;
      logic [RW-1:0] got_exp;
      logic [DW-1:0] beat;
      waited = 0;
      while (mem_rd_req !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      checkOutput("req_seen", RW'(mem_rd_req), RW'(1));
      checkOutput("req_addr", RW'(mem_start_addr), RW'(exp_addr));
      checkOutput("req_bytes", RW'(mem_bytes), RW'(eb));
      exp_row = '0;
      for (int k = 0; k < MB; k++) begin
         if (k < int'(eb)) exp_row[8*k +: 8] = dbase + 8'(k);
      end
      sb_q.push_back(exp_row);
      nb = (int'(eb) + 15) / 16;
      tick();
      checkOutput("req_held", RW'(mem_rd_req), RW'(1));
      for (int b = 0; b < nb; b++) begin
         if (b > 0) repeat (gap) tick();
         for (int j = 0; j < 16; j++) beat[8*j +: 8] = dbase + 8'(16*b + j);
         mem_data     = beat;
         mem_data_vld = 1'b1;
         tick();
         mem_data_vld = 1'b0;
         if (b == 0) checkOutput("req_drop", RW'(mem_rd_req), RW'(0));
      end
      checkOutput("row_vld_rise", RW'(row_vld), RW'(1));
      if (sb_q.size() > 0) got_exp = sb_q.pop_front();
      else got_exp = 'x;
      checkOutput("row_data", row_data, got_exp);
      for (int i = 0; i < bp; i++) begin
         if (stray && i == 3) begin
            mem_data     = '1;
            mem_data_vld = 1'b1;
         end
         if (stray && i == 5) begin
            start     = 1'b1;
            base_addr = 12'h7AB;
         end
         tick();
         mem_data_vld = 1'b0;
         start        = 1'b0;
         checkOutput("bp_vld", RW'(row_vld), RW'(1));
         checkOutput("bp_data", row_data, got_exp);
         checkOutput("bp_no_req", RW'(mem_rd_req), RW'(0));
      end
      row_rdy = 1'b1;
      tick();
      row_rdy = 1'b0;
   endtask

   task automatic runJob(input logic [AW-1:0] base, input logic [AW-1:0] stride, input logic [7:0] n,
                         input logic [LB-1:0] nbytes, input logic [7:0] dbase, input int gap,
                         input int bp, input bit stray);
      logic [LB-1:0] eb;
      logic [AW-1:0] a;
      eb = (nbytes > LB'(MB)) ? LB'(MB) : nbytes;
      applyStimulus(base, stride, n, nbytes);
      checkOutput("busy_rise", RW'(busy), RW'(1));
      a = base;
      for (int r = 0; r < int'(n); r++) begin
         serveRow(a, eb, dbase + 8'(r * 5), gap, (r == 0) ? bp : 0, stray && (r == 0));
         a = a + stride;
         if (r < int'(n) - 1) begin
            checkOutput("next_row_vld", RW'(row_vld), RW'(0));
            checkOutput("next_req", RW'(mem_rd_req), RW'(1));
         end
      end
      checkOutput("done_pulse", RW'(done), RW'(1));
      checkOutput("done_busy", RW'(busy), RW'(0));
      checkOutput("done_row_vld", RW'(row_vld), RW'(0));
      tick();
      checkOutput("done_clear", RW'(done), RW'(0));
   endtask

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      base_addr    = '0;
      row_stride   = '0;
      rows         = '0;
      row_bytes    = '0;
      mem_data     = '0;
      mem_data_vld = 1'b0;
      row_rdy      = 1'b0;
      repeat (3) tick();
      checkOutput("rst_busy", RW'(busy), RW'(0));
      checkOutput("rst_done", RW'(done), RW'(0));
      checkOutput("rst_req", RW'(mem_rd_req), RW'(0));
      checkOutput("rst_addr", RW'(mem_start_addr), RW'(0));
      checkOutput("rst_bytes", RW'(mem_bytes), RW'(0));
      checkOutput("rst_row_vld", RW'(row_vld), RW'(0));
      checkOutput("rst_row_data", row_data, RW'(0));
      rst = 1'b0;
      tick();

      $display("[TB] single row, one beat");
      runJob(12'h100, 12'h020, 8'd1, 5'd9, 8'h00, 0, 0, 1'b0);

      $display("[TB] two-beat rows with gaps");
      runJob(12'h100, 12'h020, 8'd3, 5'd20, 8'h40, 2, 0, 1'b0);

      $display("[TB] backpressure with stray beat and start");
      runJob(12'h200, 12'h010, 8'd2, 5'd12, 8'h80, 0, 10, 1'b1);

      $display("[TB] address wrap");
      runJob(12'hFF0, 12'h020, 8'd2, 5'd16, 8'h10, 1, 0, 1'b0);

      $display("[TB] degenerate jobs");
      applyStimulus(12'h100, 12'h010, 8'd0, 5'd9);
      checkOutput("deg_rows_done", RW'(done), RW'(1));
      checkOutput("deg_rows_busy", RW'(busy), RW'(0));
      checkOutput("deg_rows_req", RW'(mem_rd_req), RW'(0));
      tick();
      checkOutput("deg_rows_clear", RW'(done), RW'(0));
      checkOutput("deg_rows_req2", RW'(mem_rd_req), RW'(0));
      applyStimulus(12'h100, 12'h010, 8'd3, 5'd0);
      checkOutput("deg_bytes_done", RW'(done), RW'(1));
      checkOutput("deg_bytes_busy", RW'(busy), RW'(0));
      checkOutput("deg_bytes_req", RW'(mem_rd_req), RW'(0));
      tick();
      checkOutput("deg_bytes_clear", RW'(done), RW'(0));
      runJob(12'h300, 12'h008, 8'd1, 5'd31, 8'h20, 0, 0, 1'b0);

      $display("[TB] reset mid-row");
      applyStimulus(12'h0A0, 12'h010, 8'd1, 5'd20);
      mem_data     = {16{8'h55}};
      mem_data_vld = 1'b1;
      tick();
      mem_data_vld = 1'b0;
      checkOutput("recv_busy", RW'(busy), RW'(1));
      rst = 1'b1;
      #1;
      checkOutput("arst_busy", RW'(busy), RW'(0));
      checkOutput("arst_req", RW'(mem_rd_req), RW'(0));
      checkOutput("arst_addr", RW'(mem_start_addr), RW'(0));
      checkOutput("arst_bytes", RW'(mem_bytes), RW'(0));
      checkOutput("arst_row_vld", RW'(row_vld), RW'(0));
      checkOutput("arst_row_data", row_data, RW'(0));
      checkOutput("arst_done", RW'(done), RW'(0));
      #2;
      rst = 1'b0;
      tick();
      checkOutput("post_rst_busy", RW'(busy), RW'(0));
      checkOutput("post_rst_req", RW'(mem_rd_req), RW'(0));
      runJob(12'h040, 12'h004, 8'd1, 5'd18, 8'h60, 0, 2, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
